// File: rtl/dev_bridge_pkg.sv
// dev_bridge_pkg: slot indices, status-window offsets and FSM states shared by the bridge.
package dev_bridge_pkg;
    localparam logic [2:0] SLOT_TIMER    = 3'd0;
    localparam logic [2:0] SLOT_SWITCH   = 3'd1;
    localparam logic [2:0] SLOT_DLED     = 3'd2;
    localparam logic [2:0] SLOT_UART     = 3'd3;
    localparam logic [2:0] STAT_SLOT     = 3'd7;
    localparam logic [1:0] STAT_OFF_IRQ  = 2'd0;
    localparam logic [1:0] STAT_OFF_ERR  = 2'd1;
    localparam logic [1:0] STAT_OFF_MASK = 2'd2;
    typedef enum logic {IDLE, ACCESS} state_t;
endpackage

// File: rtl/dev_bridge_irq_ctrl.sv
// bridge_irq_ctrl: edge-detected sticky pending bits with W1C and registered HWInt; BRIDGE_IRQ_MASK_EN adds a mask register.
module bridge_irq_ctrl
    import dev_bridge_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_irq,
    input  logic       i_we,
    input  logic [1:0] i_off,
    input  logic [3:0] i_wdata,
    output logic [3:0] o_pending,
    output logic [3:0] o_mask_rd,
    output logic [5:0] o_hwint
);
    logic [3:0] r_pending, r_irq_prev, w_clr, w_pending_nxt, w_mask;
    logic [5:0] r_hwint;
    assign w_clr = (i_we && i_off == STAT_OFF_IRQ) ? i_wdata : 4'h0;
    // a new rising edge is OR-ed in after the clear, so set wins over W1C
    assign w_pending_nxt = (r_pending & ~w_clr) | (i_irq & ~r_irq_prev);
`ifdef BRIDGE_IRQ_MASK_EN
    logic [3:0] r_mask;
    assign w_mask    = (i_we && i_off == STAT_OFF_MASK) ? i_wdata : r_mask;
    assign o_mask_rd = r_mask;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_mask <= 4'hF;
        else       r_mask <= w_mask;
`else
    assign w_mask    = 4'hF;
    assign o_mask_rd = 4'h0;
`endif
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            r_irq_prev <= 4'h0;
            r_pending  <= 4'h0;
            r_hwint    <= 6'h0;
        end else begin
            r_irq_prev <= i_irq;
            r_pending  <= w_pending_nxt;
            r_hwint    <= {2'b00, w_pending_nxt & w_mask};
        end
    assign o_pending = r_pending;
    assign o_hwint   = r_hwint;
endmodule

// File: rtl/dev_bridge.sv
// dev_bridge: registered CPU-to-peripheral bridge, 4 device slots plus status window, 1-cycle access latency (BRIDGE_IRQ_MASK_EN adds IRQ mask).
module dev_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          N_DEV     = 4,
    parameter logic [2:0]  STAT_SLOT = 3'd7
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] PrAddr_I,
    input  logic [31:0] PrWD_I,
    input  logic        PrWE_I,
    input  logic        PrRE_I,
    output logic [31:0] PrRD_O,
    output logic        PrAck_O,
    output logic [5:0]  HWInt_O,
    output logic [1:0]  DEV_ADDR_O,
    output logic [31:0] DEV_DAT_O,
    output logic [3:0]  DEV_WE_O,
    input  logic [31:0] DEV0_DAT_I,
    input  logic [31:0] DEV1_DAT_I,
    input  logic [31:0] DEV2_DAT_I,
    input  logic [31:0] DEV3_DAT_I,
    input  logic [3:0]  DEV_IRQ_I
);
    import dev_bridge_pkg::*;
    state_t      r_state, w_state_nxt;
    logic        r_ack, r_wr, r_dev, r_stat;
    logic        w_req, w_base, w_dev, w_stat, w_start, w_stat_we;
    logic [31:0] r_rd, r_dat, w_rd, w_dev_rd, w_stat_rd;
    logic [3:0]  r_we, w_pending, w_mask_rd;
    logic [1:0]  r_addr;
    logic [7:0]  r_err;
    assign w_req     = PrWE_I | PrRE_I;
    assign w_base    = PrAddr_I[31:7] == BASE_ADDR[31:7];
    assign w_dev     = w_base && (int'(PrAddr_I[6:4]) < N_DEV);
    assign w_stat    = w_base && PrAddr_I[6:4] == STAT_SLOT;
    assign w_start   = r_state == IDLE && w_req;
    assign w_stat_we = r_state == ACCESS && r_wr && r_stat;
    always_comb begin
        w_state_nxt = w_start ? ACCESS : IDLE;
    end
    always_comb begin
        w_dev_rd  = PrAddr_I[6:4] == SLOT_TIMER  ? DEV0_DAT_I :
                    PrAddr_I[6:4] == SLOT_SWITCH ? DEV1_DAT_I :
                    PrAddr_I[6:4] == SLOT_DLED   ? DEV2_DAT_I : DEV3_DAT_I;
        w_stat_rd = PrAddr_I[3:2] == STAT_OFF_IRQ  ? {16'h0, r_err, 4'h0, w_pending} :
                    PrAddr_I[3:2] == STAT_OFF_MASK ? {28'h0, w_mask_rd} : 32'h0;
        w_rd      = PrWE_I ? 32'h0 : w_dev ? w_dev_rd : w_stat ? w_stat_rd : 32'h0;
    end
    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_rd    <= 32'h0;
            r_we    <= 4'h0;
            r_addr  <= 2'h0;
            r_dat   <= 32'h0;
            r_wr    <= 1'b0;
            r_dev   <= 1'b0;
            r_stat  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_start;
            r_we    <= 4'h0;
            if (w_start) begin
                r_wr   <= PrWE_I;
                r_dev  <= w_dev;
                r_stat <= w_stat;
                r_addr <= PrAddr_I[3:2];
                r_dat  <= PrWD_I;
                r_rd   <= w_rd;
                r_we   <= (PrWE_I && w_dev) ? 4'b0001 << PrAddr_I[5:4] : 4'h0;
            end
        end
    // status side effects and error counting land on the closing edge of ACCESS
    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I)
            r_err <= 8'h0;
        else if (w_stat_we && r_addr == STAT_OFF_ERR)
            r_err <= 8'h0;
        else if (r_state == ACCESS && !r_dev && !r_stat && r_err != 8'hFF)
            r_err <= r_err + 8'd1;
    bridge_irq_ctrl u_irq (
        .i_clk     (CLK_I),
        .i_rst     (RST_I),
        .i_irq     (DEV_IRQ_I),
        .i_we      (w_stat_we),
        .i_off     (r_addr),
        .i_wdata   (r_dat[3:0]),
        .o_pending (w_pending),
        .o_mask_rd (w_mask_rd),
        .o_hwint   (HWInt_O)
    );
    assign PrAck_O    = r_ack;
    assign PrRD_O     = r_rd;
    assign DEV_WE_O   = r_we;
    assign DEV_ADDR_O = r_addr;
    assign DEV_DAT_O  = r_dat;
endmodule

// File: tb/tb_dev_bridge.sv
// tb_dev_bridge: scoreboard-driven bench for dev_bridge (mask checks follow BRIDGE_IRQ_MASK_EN).
module tb_dev_bridge;
    localparam logic [31:0] BASE = 32'h0000_7F00;
    logic        CLK_I = 1'b0, RST_I = 1'b1;
    logic [31:0] PrAddr_I = '0, PrWD_I = '0;
    logic        PrWE_I = 1'b0, PrRE_I = 1'b0;
    logic [31:0] PrRD_O, DEV_DAT_O;
    logic        PrAck_O;
    logic [5:0]  HWInt_O;
    logic [1:0]  DEV_ADDR_O;
    logic [3:0]  DEV_WE_O;
    logic [31:0] DEV0_DAT_I = 32'h0D0D_1111, DEV1_DAT_I = 32'hA5A5_0F0F;
    logic [31:0] DEV2_DAT_I = 32'h2222_BEEF, DEV3_DAT_I = 32'h3333_C0DE;
    logic [3:0]  DEV_IRQ_I = '0;
    typedef struct {
        logic [31:0] rd;
        logic [3:0]  we;
        logic [1:0]  addr;
        logic [31:0] dat;
    } exp_t;
    exp_t sb[$];
    exp_t m_e;
    int total = 0, bad = 0;

    dev_bridge dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .PrAddr_I(PrAddr_I), .PrWD_I(PrWD_I),
        .PrWE_I(PrWE_I), .PrRE_I(PrRE_I), .PrRD_O(PrRD_O), .PrAck_O(PrAck_O),
        .HWInt_O(HWInt_O), .DEV_ADDR_O(DEV_ADDR_O), .DEV_DAT_O(DEV_DAT_O),
        .DEV_WE_O(DEV_WE_O), .DEV0_DAT_I(DEV0_DAT_I), .DEV1_DAT_I(DEV1_DAT_I),
        .DEV2_DAT_I(DEV2_DAT_I), .DEV3_DAT_I(DEV3_DAT_I), .DEV_IRQ_I(DEV_IRQ_I)
    );

    always #5 CLK_I = ~CLK_I;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    always @(negedge CLK_I)
        if (!RST_I && PrAck_O) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack: got ack with addr=%0d we=%b, required no ack", DEV_ADDR_O, DEV_WE_O);
            end else begin
                m_e = sb.pop_front();
                if (PrRD_O !== m_e.rd || DEV_WE_O !== m_e.we || DEV_ADDR_O !== m_e.addr ||
                    (m_e.we != 4'h0 && DEV_DAT_O !== m_e.dat)) begin
                    bad++;
                    $display("FAIL scoreboard: got rd=%h we=%b addr=%0d dat=%h, required rd=%h we=%b addr=%0d dat=%h",
                             PrRD_O, DEV_WE_O, DEV_ADDR_O, DEV_DAT_O, m_e.rd, m_e.we, m_e.addr, m_e.dat);
                end
            end
        end

    task automatic access(input logic we, re, input logic [31:0] addr, wd, exp_rd, input logic [3:0] exp_we);
        exp_t e;
        int n;
        e = '{exp_rd, exp_we, addr[3:2], wd};
        sb.push_back(e);
        PrWE_I = we; PrRE_I = re; PrAddr_I = addr; PrWD_I = wd;
        n = 0;
        do begin @(negedge CLK_I); n++; end while (!PrAck_O && n < 4);
        PrWE_I = 1'b0; PrRE_I = 1'b0;
        total++;
        if (!PrAck_O || n != 1) begin
            bad++;
            $display("FAIL ack_latency addr=%h: got ack=%b after %0d cycles, required ack=1 after 1", addr, PrAck_O, n);
            if (!PrAck_O) void'(sb.pop_back());
        end
        @(negedge CLK_I);
        total++;
        if (PrAck_O !== 1'b0 || DEV_WE_O !== 4'h0) begin
            bad++;
            $display("FAIL ack_pulse addr=%h: got ack=%b we=%b, required ack=0 we=0000", addr, PrAck_O, DEV_WE_O);
        end
    endtask

    task automatic pulse_irq(input int k);
        DEV_IRQ_I[k] = 1'b1;
        @(negedge CLK_I);
        DEV_IRQ_I[k] = 1'b0;
        repeat (2) @(negedge CLK_I);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge CLK_I);
        total++;
        if ({PrAck_O, PrRD_O, DEV_WE_O, DEV_ADDR_O, DEV_DAT_O, HWInt_O} !== '0) begin
            bad++;
            $display("FAIL reset: got ack=%b rd=%h we=%b addr=%0d dat=%h int=%b, required all zero",
                     PrAck_O, PrRD_O, DEV_WE_O, DEV_ADDR_O, DEV_DAT_O, HWInt_O);
        end
        RST_I = 1'b0;
        @(negedge CLK_I);
    endtask

    task automatic test_write;
        access(1, 0, BASE + 32'h20, 32'h1234_5678, 32'h0, 4'b0100);
        access(1, 0, BASE + 32'h3C, 32'h0000_ABCD, 32'h0, 4'b1000);
        access(1, 0, BASE + 32'h04, 32'h5555_AAAA, 32'h0, 4'b0001);
    endtask

    task automatic test_read;
        access(0, 1, BASE + 32'h14, 32'h0, 32'hA5A5_0F0F, 4'h0);
        access(0, 1, BASE + 32'h08, 32'h0, 32'h0D0D_1111, 4'h0);
        access(0, 1, BASE + 32'h2C, 32'h0, 32'h2222_BEEF, 4'h0);
    endtask

    task automatic test_unmapped;
        for (int i = 0; i < 3; i++) access(1, 0, BASE + 32'h50, 32'hFFFF_FFFF, 32'h0, 4'h0);
        access(0, 1, BASE + 32'h70, 32'h0, 32'h0000_0300, 4'h0);
        access(0, 1, 32'h0000_0010, 32'h0, 32'h0, 4'h0);
        access(0, 1, BASE + 32'h70, 32'h0, 32'h0000_0400, 4'h0);
        for (int i = 0; i < 256; i++) access(1, 0, BASE + 32'h60, i, 32'h0, 4'h0);
        access(0, 1, BASE + 32'h70, 32'h0, 32'h0000_FF00, 4'h0);
        access(1, 0, BASE + 32'h74, 32'h0, 32'h0, 4'h0);
        access(0, 1, BASE + 32'h70, 32'h0, 32'h0, 4'h0);
        access(0, 1, BASE + 32'h7C, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_irq;
        exp_t e;
        pulse_irq(3);
        total++;
        if (HWInt_O !== 6'b001000) begin
            bad++;
            $display("FAIL irq_set: got HWInt=%b, required 001000", HWInt_O);
        end
        repeat (3) @(negedge CLK_I);
        total++;
        if (HWInt_O !== 6'b001000) begin
            bad++;
            $display("FAIL irq_hold: got HWInt=%b, required 001000", HWInt_O);
        end
        access(0, 1, BASE + 32'h70, 32'h0, 32'h0000_0008, 4'h0);
        e = '{32'h0, 4'h0, 2'd0, 32'h8};
        sb.push_back(e);
        PrWE_I = 1'b1; PrAddr_I = BASE + 32'h70; PrWD_I = 32'h8;
        @(negedge CLK_I);
        PrWE_I = 1'b0;
        DEV_IRQ_I[3] = 1'b1;
        @(negedge CLK_I);
        DEV_IRQ_I[3] = 1'b0;
        total++;
        if (HWInt_O !== 6'b001000) begin
            bad++;
            $display("FAIL w1c_vs_edge: got HWInt=%b, required 001000", HWInt_O);
        end
        @(negedge CLK_I);
        access(1, 0, BASE + 32'h70, 32'h8, 32'h0, 4'h0);
        total++;
        if (HWInt_O !== 6'b000000) begin
            bad++;
            $display("FAIL w1c_clear: got HWInt=%b, required 000000", HWInt_O);
        end
    endtask

    task automatic test_both;
        access(0, 1, BASE + 32'h04, 32'h0, 32'h0D0D_1111, 4'h0);
        access(1, 1, BASE + 32'h00, 32'hCAFE_0001, 32'h0, 4'b0001);
    endtask

    task automatic test_ignored;
        exp_t e;
        e = '{32'hA5A5_0F0F, 4'h0, 2'd0, 32'h0};
        sb.push_back(e);
        PrRE_I = 1'b1; PrAddr_I = BASE + 32'h10;
        @(negedge CLK_I);
        PrRE_I = 1'b0; PrWE_I = 1'b1; PrAddr_I = BASE + 32'h30; PrWD_I = 32'hDEAD_BEEF;
        @(negedge CLK_I);
        PrWE_I = 1'b0;
        total++;
        if (PrAck_O !== 1'b0 || DEV_WE_O !== 4'h0) begin
            bad++;
            $display("FAIL ignored_req: got ack=%b we=%b, required ack=0 we=0000", PrAck_O, DEV_WE_O);
        end
        @(negedge CLK_I);
        total++;
        if (PrAck_O !== 1'b0 || DEV_WE_O !== 4'h0 || PrRD_O !== 32'hA5A5_0F0F) begin
            bad++;
            $display("FAIL ignored_hold: got ack=%b we=%b rd=%h, required ack=0 we=0000 rd=a5a50f0f", PrAck_O, DEV_WE_O, PrRD_O);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        e = '{32'h3333_C0DE, 4'h0, 2'd1, 32'h0};
        sb.push_back(e);
        sb.push_back(e);
        PrRE_I = 1'b1; PrAddr_I = BASE + 32'h34;
        @(negedge CLK_I);
        @(negedge CLK_I);
        total++;
        if (PrAck_O !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: got ack=%b, required 0", PrAck_O);
        end
        @(negedge CLK_I);
        PrRE_I = 1'b0;
        @(negedge CLK_I);
        total++;
        if (PrAck_O !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: got ack=%b, required 0", PrAck_O);
        end
    endtask

    task automatic test_mask;
`ifdef BRIDGE_IRQ_MASK_EN
        access(0, 1, BASE + 32'h78, 32'h0, 32'h0000_000F, 4'h0);
        access(1, 0, BASE + 32'h78, 32'hE, 32'h0, 4'h0);
        pulse_irq(0);
        total++;
        if (HWInt_O !== 6'b000000) begin
            bad++;
            $display("FAIL mask_block: got HWInt=%b, required 000000", HWInt_O);
        end
        access(0, 1, BASE + 32'h70, 32'h0, 32'h0000_0001, 4'h0);
        access(1, 0, BASE + 32'h78, 32'hF, 32'h0, 4'h0);
        total++;
        if (HWInt_O !== 6'b000001) begin
            bad++;
            $display("FAIL mask_open: got HWInt=%b, required 000001", HWInt_O);
        end
`else
        access(0, 1, BASE + 32'h78, 32'h0, 32'h0, 4'h0);
        access(1, 0, BASE + 32'h78, 32'hE, 32'h0, 4'h0);
        pulse_irq(0);
        total++;
        if (HWInt_O !== 6'b000001) begin
            bad++;
            $display("FAIL no_mask: got HWInt=%b, required 000001", HWInt_O);
        end
        access(0, 1, BASE + 32'h78, 32'h0, 32'h0, 4'h0);
`endif
        access(1, 0, BASE + 32'h70, 32'hF, 32'h0, 4'h0);
    endtask

    task automatic test_async_reset;
        pulse_irq(1);
        PrWE_I = 1'b1; PrAddr_I = BASE + 32'h2C; PrWD_I = 32'h0BAD_F00D;
        @(posedge CLK_I);
        #1;
        total++;
        if (DEV_WE_O !== 4'b0100 || PrAck_O !== 1'b1 || HWInt_O !== 6'b000010) begin
            bad++;
            $display("FAIL pre_reset: got we=%b ack=%b int=%b, required we=0100 ack=1 int=000010", DEV_WE_O, PrAck_O, HWInt_O);
        end
        #1 RST_I = 1'b1;
        #1;
        total++;
        if ({PrAck_O, PrRD_O, DEV_WE_O, DEV_ADDR_O, DEV_DAT_O, HWInt_O} !== '0) begin
            bad++;
            $display("FAIL async_reset: got ack=%b rd=%h we=%b addr=%0d dat=%h int=%b, required all zero",
                     PrAck_O, PrRD_O, DEV_WE_O, DEV_ADDR_O, DEV_DAT_O, HWInt_O);
        end
        PrWE_I = 1'b0;
        @(negedge CLK_I);
        RST_I = 1'b0;
        repeat (2) @(negedge CLK_I);
        total++;
        if (PrAck_O !== 1'b0 || DEV_WE_O !== 4'h0) begin
            bad++;
            $display("FAIL post_reset: got ack=%b we=%b, required ack=0 we=0000", PrAck_O, DEV_WE_O);
        end
        access(0, 1, BASE + 32'h70, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_unmapped;
        test_irq;
        test_both;
        test_ignored;
        test_back_to_back;
        test_mask;
        test_async_reset;
        repeat (2) @(negedge CLK_I);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dev_bridge.md
Name: dev_bridge

Overview:
- Registered system bridge between the CPU data-memory port and the memory-mapped peripheral bus.
- Decodes the CPU address into 4 device slots, of which slot 2 is the digital LED display. Fans out write data and write enables. Returns read data with a fixed 1-cycle access latency.
- Aggregates device interrupt lines into sticky pending bits driven to the CPU as HWInt_O.
- Owns a small status window for interrupt clear and bus-error count.

Parameters:
- BASE_ADDR, 32'h0000_7F00, base of the device window; slot k at BASE_ADDR + k*16.
- N_DEV, 4, number of device slots (fixed 4 for this revision).
- STAT_SLOT, 7, slot index of the bridge status window.

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  asynchronous active-high reset
- PrAddr_I  in  32  CPU byte address
- PrWD_I  in  32  CPU write data
- PrWE_I  in  1  CPU write request
- PrRE_I  in  1  CPU read request
- PrRD_O  out  32  read data, valid while PrAck_O=1
- PrAck_O  out  1  access complete, 1-cycle pulse
- HWInt_O  out  6  interrupt lines to CPU; [3:0]=pending, [5:4]=0
- DEV_ADDR_O  out  2  word offset inside slot (addr[3:2])
- DEV_DAT_O  out  32  shared write data to devices
- DEV_WE_O  out  4  one-hot write enable per slot
- DEV0_DAT_I..DEV3_DAT_I  in  32 each  device read data (DAT_O of each device)
- DEV_IRQ_I  in  4  device interrupt request levels

Behaviour:
- Clock and reset: single clock CLK_I. RST_I is asynchronous, active-high.
- Reset values: state=IDLE, PrAck_O=0, PrRD_O=0, DEV_WE_O=0, DEV_ADDR_O=0, DEV_DAT_O=0, pending=0, err_cnt=0, irq_prev=0, HWInt_O=0.
- Hit decode: PrAddr_I[31:7]==BASE_ADDR[31:7] and PrAddr_I[6:4] in 0..3 selects a device slot. PrAddr_I[6:4]==STAT_SLOT selects the status window. Anything else is unmapped.
- FSM states:
  - IDLE: on PrWE_I or PrRE_I, latch address, data, direction and slot; go to ACCESS.
  - ACCESS: unconditionally return to IDLE next cycle.
- Requests arriving in ACCESS are ignored. The CPU must hold its request until PrAck_O.
- ACCESS cycle:
  - PrAck_O=1 for exactly one cycle.
  - Write: DEV_WE_O[slot]=1, DEV_DAT_O=latched data, DEV_ADDR_O=latched addr[3:2]. The device captures on the closing edge.
  - Read: PrRD_O is registered from DEVslot_DAT_I sampled at the IDLE->ACCESS edge and held until the next access.
- Latency: request to PrAck_O is 1 cycle; back-to-back throughput is 1 access per 2 cycles.
- PrWE_I and PrRE_I both high: treated as a write; no read data (PrRD_O=0).
- Unmapped access: still acknowledged. Write dropped (DEV_WE_O=0). Read returns 0. err_cnt increments, 8-bit, saturating at 255.
- Status window:
  - Offset 0 read = {16'b0, err_cnt, 4'b0, pending}.
  - Write offset 0: W1C on pending[3:0] using data[3:0].
  - Write offset 1: clears err_cnt.
  - Other offsets: read 0; writes ignored.
- Interrupts:
  - pending[k] sets on the rising edge of DEV_IRQ_I[k], using irq_prev registered each cycle.
  - pending[k] stays set until W1C.
  - Set and clear in the same cycle: set wins.
  - HWInt_O[3:0]=pending, registered.
- Reset mid-access: FSM returns to IDLE immediately. No PrAck_O, no write strobe, and the in-flight request is lost.

Optional Feature:
- Macro: BRIDGE_IRQ_MASK_EN.
- Defined:
  - Adds 4-bit mask register at status offset 2, read/write, reset 4'hF.
  - HWInt_O[3:0] = pending & mask. Pending still latches while masked.
  - Read of offset 2 returns {28'b0, mask}.
- Undefined:
  - No mask register; HWInt_O[3:0]=pending.
  - Offset 2 reads 0; writes to it are ignored.

Decomposition:
- Package dev_bridge_pkg holds:
  - slot index constants: SLOT_TIMER=0, SLOT_SWITCH=1, SLOT_DLED=2, SLOT_UART=3, STAT_SLOT=7;
  - status offset constants: STAT_OFF_IRQ=0, STAT_OFF_ERR=1, STAT_OFF_MASK=2;
  - FSM state encoding: IDLE and ACCESS.
- Sub-module bridge_irq_ctrl contains edge detect, pending register, W1C, mask and HWInt_O register.
- Decode, FSM and read mux stay in the top.

Test Plan:
- Write 32'h1234_5678 to BASE+0x20 -> next cycle DEV_WE_O=4'b0100, DEV_DAT_O=32'h1234_5678, DEV_ADDR_O=0, PrAck_O=1 for one cycle.
- DEV1_DAT_I=32'hA5A5_0F0F, read BASE+0x14 -> PrAck_O one cycle later, PrRD_O=32'hA5A5_0F0F, DEV_ADDR_O=1, DEV_WE_O=0.
- Write to BASE+0x50 three times, then read BASE+0x70 -> PrRD_O[15:8]=3, DEV_WE_O never asserted; after 256 bad writes err_cnt=255.
- Pulse DEV_IRQ_I[3]=1 for 1 cycle -> HWInt_O=6'b001000 and held; write 32'h8 to BASE+0x70 coinciding with a new IRQ3 rising edge -> pending stays 1.
- Simultaneous PrWE_I and PrRE_I to BASE+0x00 -> write performed, PrRD_O=0; a second request during ACCESS -> ignored.
- Assert RST_I asynchronously in ACCESS of a write -> DEV_WE_O and PrAck_O drop immediately, all outputs at reset values.
- With BRIDGE_IRQ_MASK_EN: mask=4'b1110, pulse IRQ0 -> HWInt_O=0 and pending[0]=1; write mask=4'hF -> HWInt_O[0]=1.
